// File: rtl/alu_operand_fetch_if.sv
// Instruction-in / operand-out handshake bundle of the ALU operand-fetch stage.
// master = upstream decoder plus ALU side, slave = the fetch stage.
interface alu_operand_fetch_if #(
  parameter int unsigned DW   = 10,
  parameter int unsigned AW   = 3,
  parameter int unsigned OPW  = 5,
  parameter int unsigned IMMW = 4
) ();
  localparam int unsigned IW = OPW + 2*AW + 1 + IMMW;

  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instr;
  logic            out_valid;
  logic            out_ready;
  logic [OPW-1:0]  opcode_o;
  logic [DW-1:0]   op1;
  logic [DW-1:0]   op2;
  logic            illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, opcode_o, op1, op2, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, opcode_o, op1, op2, illegal
  );
endinterface

// File: rtl/alu_operand_fetch.sv
// Multi-cycle operand fetch ahead of the ALU: single-port regfile reads, immediate build, illegal-opcode flag.
// Optional write-through bypass from the writeback port is enabled by defining ALU_OPFETCH_BYPASS_EN.
module alu_operand_fetch #(
  parameter int unsigned DW   = 10,
  parameter int unsigned AW   = 3,
  parameter int unsigned OPW  = 5,
  parameter int unsigned IMMW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  alu_operand_fetch_if.slave    bus,
  output logic                  rf_re,
  output logic [AW-1:0]         rf_addr,
  input  logic [DW-1:0]         rf_data,
  input  logic                  wb_we,
  input  logic [AW-1:0]         wb_addr,
  input  logic [DW-1:0]         wb_data
);
  localparam int unsigned IW = OPW + 2*AW + 1 + IMMW;

  typedef struct packed {
    logic [OPW-1:0]  opcode;
    logic [AW-1:0]   src1;
    logic [AW-1:0]   src2;
    logic            imm_sel;
    logic [IMMW-1:0] imm;
  } instr_t;

  typedef enum logic [2:0] {S_IDLE, S_RA, S_RB, S_RC, S_OUT} state_t;

  function automatic logic is_unary(input logic [OPW-1:0] op);
    return (op == OPW'(5'b00101)) || (op == OPW'(5'b00110)) || (op == OPW'(5'b10011));
  endfunction

  function automatic logic is_legal(input logic [OPW-1:0] op);
    logic legal;
    case (op)
      OPW'(5'b00101), OPW'(5'b00110), OPW'(5'b00111), OPW'(5'b01000),
      OPW'(5'b01001), OPW'(5'b01010), OPW'(5'b01011), OPW'(5'b01100),
      OPW'(5'b10011): legal = 1'b1;
      default:        legal = 1'b0;
    endcase
    return legal;
  endfunction

  function automatic logic needs_reg2(input instr_t i);
    return !is_unary(i.opcode) && !i.imm_sel;
  endfunction

  state_t          state_q, state_d;
  instr_t          instr_q, instr_d;
  logic            rf_re_q, rf_re_d;
  logic [AW-1:0]   rf_addr_q, rf_addr_d;
  logic [OPW-1:0]  opcode_q, opcode_d;
  logic [DW-1:0]   op1_q, op1_d;
  logic [DW-1:0]   op2_q, op2_d;
  logic            illegal_q, illegal_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_c;
  logic [DW-1:0]   rd_src1_c;
  logic [DW-1:0]   rd_src2_c;

  // Read data for the address issued one cycle earlier (src1 seen in RB, src2 seen in RC).
`ifdef ALU_OPFETCH_BYPASS_EN
  assign rd_src1_c = (wb_we && (wb_addr == instr_q.src1)) ? wb_data : rf_data;
  assign rd_src2_c = (wb_we && (wb_addr == instr_q.src2)) ? wb_data : rf_data;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
  assign rd_src1_c = rf_data;
  assign rd_src2_c = rf_data;
`endif

  assign in_ready_c = rst_n && (state_q == S_IDLE) && !flush;

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    rf_re_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          instr_d  = instr_t'(bus.instr);
          opcode_d = instr_d.opcode;
          op1_d    = '0;
          op2_d    = '0;
          if (!is_legal(instr_d.opcode)) begin
            illegal_d = 1'b1;
            state_d   = S_OUT;
          end else begin
            illegal_d = 1'b0;
            state_d   = S_RA;
            rf_re_d   = 1'b1;
            rf_addr_d = instr_d.src1;
          end
        end
      end
      S_RA: begin
        state_d = S_RB;
        if (needs_reg2(instr_q)) begin
          rf_re_d   = 1'b1;
          rf_addr_d = instr_q.src2;
        end
      end
      S_RB: begin
        op1_d = rd_src1_c;
        if (needs_reg2(instr_q)) begin
          state_d = S_RC;
        end else begin
          op2_d   = is_unary(instr_q.opcode) ? '0 : DW'(instr_q.imm);
          state_d = S_OUT;
        end
      end
      S_RC: begin
        op2_d   = rd_src2_c;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any progress, including an ALU handoff in the same cycle.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rf_re_d = 1'b0;
    end

    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      rf_re_q     <= 1'b0;
      rf_addr_q   <= '0;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      rf_re_q     <= rf_re_d;
      rf_addr_q   <= rf_addr_d;
      opcode_q    <= opcode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.opcode_o  = opcode_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.illegal   = illegal_q;
  assign rf_re         = rf_re_q;
  assign rf_addr       = rf_addr_q;
endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch: vector table with latency/read-count checks, scoreboard on the ALU handoff,
// plus hand sequences for backpressure, flush, mid-flight reset and writeback bypass.
`timescale 1ns/1ps
module tb_alu_operand_fetch;
  localparam int unsigned DW = 10, AW = 3, OPW = 5, IMMW = 4;

`ifdef ALU_OPFETCH_BYPASS_EN
  localparam logic [9:0] BYP_OP1 = 10'h3FF;
`else
  localparam logic [9:0] BYP_OP1 = 10'h007;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          rf_re;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data = '0;
  logic          wb_we = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;

  alu_operand_fetch_if #(.DW(DW), .AW(AW), .OPW(OPW), .IMMW(IMMW)) bus ();

  alu_operand_fetch #(.DW(DW), .AW(AW), .OPW(OPW), .IMMW(IMMW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .bus     (bus),
    .rf_re   (rf_re),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  always #5 clk = ~clk;

  // Register file model: data is valid the cycle after the read enable.
  logic [DW-1:0] regs [8];
  always @(posedge clk) if (rf_re) rf_data <= regs[rf_addr];

  typedef struct {
    logic [4:0] opc;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       sel;
    logic [3:0] imm;
    logic [9:0] e_op1;
    logic [9:0] e_op2;
    logic       e_ill;
    int         e_lat;
    int         e_nre;
  } vec_t;

  typedef struct {
    logic [4:0] opc;
    logic [9:0] op1;
    logic [9:0] op2;
    logic       ill;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];
  vec_t bvec;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare on every completed ALU handoff.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: output opcode 0x%0h with empty scoreboard", bus.opcode_o);
      end else begin : pop
        exp_t e;
        e = sb_q.pop_front();
        check("sb_opcode",  32'(bus.opcode_o), 32'(e.opc));
        check("sb_op1",     32'(bus.op1),      32'(e.op1));
        check("sb_op2",     32'(bus.op2),      32'(e.op2));
        check("sb_illegal", 32'(bus.illegal),  32'(e.ill));
      end
    end
  end

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.instr    = {v.opc, v.s1, v.s2, v.sel, v.imm};
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input vec_t v, input bit bp, output int lat, output int nre);
    lat = 0;
    nre = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rf_re) begin
        nre++;
        if (nre == 1) check("rf_addr_src1", 32'(rf_addr), 32'(v.s1));
        else          check("rf_addr_src2", 32'(rf_addr), 32'(v.s2));
      end
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bp && k == 1) begin
        @(posedge clk); #1;
        wb_we = 1'b1; wb_addr = v.s1; wb_data = 10'h3FF;
      end
      if (bp && k == 2) begin
        @(posedge clk); #1;
        wb_we = 1'b0;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit bp);
    int lat, nre;
    sb_q.push_back('{v.opc, v.e_op1, v.e_op2, v.e_ill});
    send(v);
    wait_out(v, bp, lat, nre);
    check({tag, "_latency"}, 32'(lat), 32'(v.e_lat));
    check({tag, "_rf_reads"}, 32'(nre), 32'(v.e_nre));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nre;
    bit seen;

    regs[0] = 10'h000; regs[1] = 10'h3FD; regs[2] = 10'h155; regs[3] = 10'h007;
    regs[4] = 10'h200; regs[5] = 10'h0AA; regs[6] = 10'h3FF; regs[7] = 10'h123;

    vecs[0]  = '{5'b00111, 3'd2, 3'd5, 1'b0, 4'd0,  10'h155, 10'h0AA, 1'b0, 4, 2};
    vecs[1]  = '{5'b01011, 3'd1, 3'd0, 1'b1, 4'd13, 10'h3FD, 10'h00D, 1'b0, 3, 1};
    vecs[2]  = '{5'b10011, 3'd4, 3'd7, 1'b0, 4'd5,  10'h200, 10'h000, 1'b0, 3, 1};
    vecs[3]  = '{5'b00000, 3'd2, 3'd5, 1'b0, 4'd3,  10'h000, 10'h000, 1'b1, 1, 0};
    vecs[4]  = '{5'b00101, 3'd6, 3'd1, 1'b1, 4'd15, 10'h3FF, 10'h000, 1'b0, 3, 1};
    vecs[5]  = '{5'b01000, 3'd3, 3'd3, 1'b0, 4'd0,  10'h007, 10'h007, 1'b0, 4, 2};
    vecs[6]  = '{5'b11111, 3'd2, 3'd2, 1'b1, 4'd9,  10'h000, 10'h000, 1'b1, 1, 0};
    vecs[7]  = '{5'b01100, 3'd7, 3'd0, 1'b0, 4'd0,  10'h123, 10'h000, 1'b0, 4, 2};
    vecs[8]  = '{5'b01001, 3'd0, 3'd4, 1'b1, 4'd0,  10'h000, 10'h000, 1'b0, 3, 1};
    vecs[9]  = '{5'b00110, 3'd5, 3'd6, 1'b0, 4'd7,  10'h0AA, 10'h000, 1'b0, 3, 1};
    vecs[10] = '{5'b01010, 3'd4, 3'd6, 1'b0, 4'd0,  10'h200, 10'h3FF, 1'b0, 4, 2};
    vecs[11] = '{5'b10100, 3'd1, 3'd1, 1'b0, 4'd0,  10'h000, 10'h000, 1'b1, 1, 0};
    bvec     = '{5'b00101, 3'd3, 3'd0, 1'b0, 4'd0,  BYP_OP1, 10'h000, 1'b0, 3, 1};

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;

    // Reset values while rst_n is held low
    #7;
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rf_re",     32'(rf_re),         32'd0);
    check("rst_rf_addr",   32'(rf_addr),       32'd0);
    check("rst_opcode",    32'(bus.opcode_o),  32'd0);
    check("rst_op1",       32'(bus.op1),       32'd0);
    check("rst_op2",       32'(bus.op2),       32'd0);
    check("rst_illegal",   32'(bus.illegal),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec($sformatf("v%0d", i), vecs[i], 1'b0);

    run_vec("bypass", bvec, 1'b1);

    // Backpressure: outputs held while the ALU stalls
    sb_q.push_back('{vecs[0].opc, vecs[0].e_op1, vecs[0].e_op2, vecs[0].e_ill});
    bus.out_ready = 1'b0;
    send(vecs[0]);
    wait_out(vecs[0], 1'b0, lat, nre);
    check("bp_latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp_op1_hold",   32'(bus.op1),       32'h155);
      check("bp_op2_hold",   32'(bus.op2),       32'h0AA);
      check("bp_in_ready",   32'(bus.in_ready),  32'd0);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_in_ready", 32'(bus.in_ready),  32'd1);
    check("bp_release_valid",    32'(bus.out_valid), 32'd0);

    // Flush during RB
    send(vecs[0]);
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    check("flush_rb_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_rb_rf_re",    32'(rf_re),        32'd0);
    check("flush_rb_in_ready_after", 32'(bus.in_ready), 32'd1);
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.out_valid) seen = 1'b1; end
    check("flush_rb_no_valid", 32'(seen), 32'd0);

    // Flush together with in_valid in IDLE: not accepted
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.instr    = {vecs[1].opc, vecs[1].s1, vecs[1].s2, vecs[1].sel, vecs[1].imm};
    flush        = 1'b1;
    @(negedge clk);
    check("flush_idle_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.out_valid || rf_re) seen = 1'b1; end
    check("flush_idle_no_accept", 32'(seen), 32'd0);

    // Flush in OUT with out_ready high: handoff dropped
    send(vecs[3]);
    flush = 1'b1;
    @(negedge clk);
    check("flush_out_valid_before", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid_after", 32'(bus.out_valid), 32'd0);
    check("flush_out_in_ready",    32'(bus.in_ready),  32'd1);

    // Reset asserted in RC, then a normal instruction
    send(vecs[0]);
    @(posedge clk);
    @(posedge clk); #1;
    check("rc_op1_before", 32'(bus.op1), 32'h155);
    #2 rst_n = 1'b0;
    #1;
    check("rc_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rc_rst_rf_re",     32'(rf_re),         32'd0);
    check("rc_rst_op1",       32'(bus.op1),       32'd0);
    check("rc_rst_op2",       32'(bus.op2),       32'd0);
    check("rc_rst_opcode",    32'(bus.opcode_o),  32'd0);
    check("rc_rst_in_ready",  32'(bus.in_ready),  32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    run_vec("post_rst", vecs[1], 1'b0);

    repeat (2) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_operand_fetch.md
Name: alu_operand_fetch

Overview:
- Multi-cycle operand-fetch stage directly upstream of the ALU.
- Accepts one decoded instruction word, reads source registers through a single-port register file, and builds an immediate where the instruction selects one.
- Presents opcode/op1/op2 to the ALU with a valid/ready handshake.
- Flags opcodes the ALU does not implement, so that downstream never sees a high-Z result.

Parameters:
- DW, 10, operand data width (signed two's complement).
- AW, 3, register-file address width (8 registers).
- OPW, 5, opcode width.
- IMMW, 4, immediate width (zero-extended to DW).
- IW is derived as OPW+2*AW+1+IMMW and equals 16 with the defaults. It is a localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort of the instruction in flight.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage can accept an instruction.
- instr  in  IW  fields: [15:11] opcode, [10:8] src1, [7:5] src2, [4] imm_sel, [3:0] imm.
- rf_re  out  1  register-file read enable.
- rf_addr  out  AW  register-file read address.
- rf_data  in  DW  read data, valid the cycle after rf_re.
- wb_we  in  1  writeback write enable (used only by the optional feature).
- wb_addr  in  AW  writeback address (used only by the optional feature).
- wb_data  in  DW  writeback data (used only by the optional feature).
- out_valid  out  1  opcode_o/op1/op2/illegal are valid.
- out_ready  in  1  ALU side consumes the output.
- opcode_o  out  OPW  opcode to the ALU.
- op1  out  DW  first operand.
- op2  out  DW  second operand.
- illegal  out  1  opcode is not implemented by the ALU.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, rf_re=0, rf_addr=0, opcode_o=0, op1=0, op2=0, illegal=0.
  - in_ready is driven 0 while rst_n is low.
- Legal opcodes: 00101, 00110, 01000, 00111, 01001, 01010, 01011, 01100, 10011.
- Unary opcodes are 00101, 00110 and 10011. For these, op2=0 and src2/imm are ignored.
- Operand sources:
  - op1 always comes from register src1.
  - For binary opcodes, op2 = zero-extended imm when imm_sel=1, otherwise register src2.
- States and transitions:
  - IDLE: in_ready = !flush. Accept when in_valid & in_ready; latch instr.
    - Illegal opcode goes to OUT with illegal=1, op1=op2=0.
    - Otherwise go to RA.
  - RA: rf_re=1, rf_addr=src1. Go to RB.
  - RB: op1 <= rf_data.
    - If a register op2 is needed: rf_re=1, rf_addr=src2, go to RC.
    - Otherwise: op2 <= imm or 0, go to OUT.
  - RC: op2 <= rf_data. Go to OUT.
  - OUT: out_valid=1 with all outputs held stable. On out_ready go to IDLE.
- Latency, counting the accept edge as cycle T:
  - Two-register instruction: out_valid rises at T+4.
  - Unary or immediate instruction: T+3.
  - Illegal opcode: T+1.
- Throughput: no back-to-back acceptance. in_ready is high only in IDLE.
- rf_re is 0 in IDLE, RC and OUT.
- flush:
  - In any non-IDLE state, flush returns the block to IDLE on the next edge, with out_valid=0 and rf_re=0.
  - flush in OUT together with out_ready: flush wins; the handoff counts as dropped.
  - flush together with in_valid in IDLE: the instruction is not accepted.
- Reset asserted mid-operation aborts immediately. There is no pending state after rst_n deasserts.
- src1 == src2 still issues two reads.

Optional Feature:
- Macro: ALU_OPFETCH_BYPASS_EN.
- With the macro: in RB and RC, if wb_we=1 and wb_addr equals the rf_addr issued in the previous cycle, capture wb_data instead of rf_data (write-through bypass).
- Without the macro: wb_we, wb_addr and wb_data are present but ignored. Operands come from rf_data only.

Test Plan:
- Register pair: reset; instr opcode=00111, src1=2, src2=5, imm_sel=0; regs r2=0x155, r5=0x0AA -> rf_addr 2 at T+1, rf_addr 5 at T+2; out_valid at T+4 with op1=0x155, op2=0x0AA, illegal=0.
- Immediate and unary:
  - opcode=01011, src1=1 (r1=-3), imm_sel=1, imm=13 -> out_valid at T+3, op1=-3, op2=13, exactly one rf_re pulse.
  - opcode=10011 -> op2=0.
- Illegal opcode: opcode=00000 -> out_valid at T+1, illegal=1, op1=op2=0, rf_re never asserted.
- Backpressure: out_ready=0 for 5 cycles in OUT -> outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- Flush and reset: flush in RB -> IDLE next edge, no out_valid. rst_n low in RC -> outputs zero immediately; after release, a new instruction completes normally.
- Bypass (macro on): r3=7, wb_we=1, wb_addr=3, wb_data=0x3FF in the RB cycle after the src1=3 read -> op1=0x3FF. With the macro off -> op1=7.
